fetch_unit: RTL and testbench

//  Instruction-fetch stage of the 31-instruction MIPS core. Owns the fetch PC, computes PC+4 or

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_pc_reg.sv | 36 +++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding and PC constants.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OUT  = 2'd2,
      DROP = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
   localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_STEP      = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: sequential step or redirect load.
// Redirect targets are forced to word alignment on load.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic        sel_redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   // choose the next PC: hold, step by one word, or redirect
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         if (sel_redirect_i) pc_d = word_align(redirect_pc_i);
         else                pc_d = pc_q + PC_STEP;
      end
   end

   // PC register with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) pc_q <= RESET_PC;
      else         pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake and
// instruction register presented to decode with valid/ready.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic [31:0] pc_out,
   output logic        misalign_err
);

   fetch_state_e state_q, state_d;
   logic [31:0]  drop_addr_q;
   logic [31:0]  inst_q;
   logic [31:0]  ipc_q;
   logic         err_q;
   logic [31:0]  pc;
   logic         capture;
   logic         pc_load;

   // a returned word is kept only if no redirect arrives with it
   assign capture = (state_q == REQ) && imem_ack && !redirect_valid;
   assign pc_load = redirect_valid || capture;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk_i          (clk),
      .rst_ni         (rst),
      .load_i         (pc_load),
      .sel_redirect_i (redirect_valid),
      .redirect_pc_i  (redirect_pc),
      .pc_o           (pc)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // next-state logic; redirect takes priority over normal flow
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_ack)            state_d = redirect_valid ? REQ : OUT;
            else if (redirect_valid) state_d = DROP;
         end
         OUT: begin
            if (redirect_valid || inst_ready) state_d = REQ;
         end
         DROP: begin
            if (imem_ack) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   // outputs decoded from state; a dropped request keeps its old address
   always_comb begin
      imem_req   = (state_q == REQ) || (state_q == DROP);
      imem_addr  = (state_q == DROP) ? drop_addr_q : pc;
      inst_valid = (state_q == OUT);
      inst_out   = inst_valid ? inst_q : NOP_WORD;
   end

   // abandoned address, instruction register and sticky misalign flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         drop_addr_q <= '0;
         inst_q      <= NOP_WORD;
         ipc_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         if (state_q == REQ && !imem_ack && redirect_valid)
            drop_addr_q <= pc;
         if (capture) begin
            inst_q <= imem_rdata;
            ipc_q  <= pc;
         end
         if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            err_q <= 1'b1;
      end
   end

   assign inst_pc      = ipc_q;
   assign pc_out       = pc;
   assign misalign_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic,
// compared each cycle against a transaction-level model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic [31:0] pc_out;
   logic        misalign_err;

   int vectors = 0;
   int miscompares = 0;

   // model: an outstanding request (busy), whether its data is
   // to be thrown away (discard), a held instruction (hold)
   logic [31:0] m_pc;
   logic [31:0] m_req_addr;
   logic [31:0] m_inst;
   logic [31:0] m_ipc;
   logic        m_busy, m_discard, m_hold, m_start, m_err;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_out       (inst_out),
      .inst_pc        (inst_pc),
      .pc_out         (pc_out),
      .misalign_err   (misalign_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic issue(input logic [31:0] a);
      m_busy     = 1'b1;
      m_discard  = 1'b0;
      m_req_addr = a;
   endtask

   task automatic model_step();
      logic [31:0] npc;
      logic        cap;
      if (!rst) begin
         m_pc = 32'h0040_0000; m_busy = 0; m_discard = 0;
         m_hold = 0; m_start = 1; m_err = 0; m_ipc = '0;
         m_inst = '0; m_req_addr = '0;
         return;
      end
      npc = m_pc;
      cap = m_busy && imem_ack && !m_discard && !redirect_valid;
      if (cap) begin
         m_inst = imem_rdata;
         m_ipc  = m_req_addr;
         npc    = m_pc + 32'd4;
      end
      if (redirect_valid) begin
         npc = {redirect_pc[31:2], 2'b00};
         if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
      end
      if (m_start) begin
         m_start = 1'b0;
         issue(npc);
      end else if (m_busy) begin
         if (imem_ack) begin
            if (cap) begin
               m_busy = 1'b0;
               m_hold = 1'b1;
            end else issue(npc);
         end else if (redirect_valid) m_discard = 1'b1;
      end else if (m_hold) begin
         if (redirect_valid || inst_ready) begin
            m_hold = 1'b0;
            issue(npc);
         end
      end
      m_pc = npc;
   endtask

   task automatic check();
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
      if (m_busy) chk("imem_addr", imem_addr, m_req_addr);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_hold});
      chk("inst_out", inst_out, m_hold ? m_inst : 32'h0);
      chk("inst_pc", inst_pc, m_ipc);
      chk("pc_out", pc_out, m_pc);
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
   endtask

   task automatic tick(input logic rs, input logic rv,
                       input logic [31:0] rp, input logic ak,
                       input logic rd);
      rst            = rs;
      redirect_valid = rv;
      redirect_pc    = rp;
      imem_ack       = ak;
      inst_ready     = rd;
      imem_rdata     = $urandom;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check();
   endtask

   task automatic run(input int n, input logic ak, input logic rd);
      for (int i = 0; i < n; i++) tick(1, 0, '0, ak, rd);
   endtask

   initial begin
      // reset state
      tick(0, 0, '0, 1, 1);
      tick(0, 0, '0, 1, 1);
      chk("reset_pc", pc_out, 32'h0040_0000);
      // zero-wait memory, decode always ready
      run(8, 1, 1);
      // delayed ack, then held by decode
      tick(0, 0, '0, 0, 1);
      tick(1, 0, '0, 0, 1);
      run(3, 0, 1);
      tick(1, 0, '0, 1, 0);
      run(5, 0, 0);
      run(1, 0, 1);
      // redirect while a request is unacked
      run(3, 1, 1);
      tick(1, 0, '0, 0, 1);
      tick(1, 1, 32'h0040_0100, 0, 1);
      run(2, 0, 1);
      tick(1, 1, 32'h0040_0200, 0, 1);
      run(4, 1, 1);
      // misaligned redirect is sticky, cleared by reset
      tick(1, 1, 32'h0040_0102, 0, 1);
      run(4, 1, 1);
      chk("err_sticky", {31'b0, misalign_err}, 32'd1);
      tick(0, 0, '0, 0, 1);
      // wrap past the top of memory, then reset mid-request
      tick(1, 0, '0, 0, 1);
      tick(1, 1, 32'hFFFF_FFFC, 0, 1);
      run(6, 1, 1);
      tick(1, 0, '0, 0, 1);
      tick(0, 0, '0, 0, 1);
      run(2, 0, 1);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         tick(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 1) == 0) ? $urandom
                 : (32'hFFFF_FFF0 | ($urandom & 32'hF)),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 2) != 0));
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
